// File: rtl/exception_trap_controller.sv
// exception_trap_controller: carries fetch faults to E, resolves the oldest fault and sequences trap/mret
module exception_trap_controller #(
  parameter int XLEN = 2,
  parameter logic [1:0] RESET_PRIV = 2'b11,
  localparam int W = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_exception_code_f,
  input  logic [3:0]   i_exception_code_e,
  input  logic [W-1:0] i_pc_f,
  input  logic [W-1:0] i_pc_e,
  input  logic [W-1:0] i_alu_out_e,
  input  logic         i_stall_d,
  input  logic         i_flush_d,
  input  logic         i_stall_e,
  input  logic         i_flush_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_mtvec,
  input  logic [W-1:0] i_mepc,
  output logic         o_kill_e,
  output logic         o_flush,
  output logic         o_csr_we,
  output logic [W-1:0] o_mepc,
  output logic [W-1:0] o_mtval,
  output logic [3:0]   o_mcause,
  output logic [1:0]   o_mpp,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc,
  output logic [1:0]   o_current_privilege,
  output logic         o_busy
);
  localparam logic [3:0] NO_E = 4'hF;
  localparam logic [3:0] E_FETCH_MIS = 4'd0;
  localparam logic [3:0] E_ILLEGAL = 4'd2;
  localparam logic [3:0] E_ECALL = 4'd8;
  localparam logic [1:0] MACHINE = 2'b11;
  typedef enum logic [1:0] {IDLE, TRAP, REDIRECT, MRET} state_t;
  state_t state, state_n;
  logic [3:0] code_d, code_e, sel, cause_n, cause_q;
  logic [W-1:0] pc_d, pc_e, mtval_n, mtval_q, mepc_q;
  logic [1:0] priv, priv_q, mpp;
  logic idle, trap;
  always_comb begin
    idle = state == IDLE;
    trap = idle && (code_e != NO_E || i_exception_code_e != NO_E || (i_mret_e && priv != MACHINE));
    sel = code_e != NO_E ? code_e : i_exception_code_e != NO_E ? i_exception_code_e : E_ILLEGAL;
    cause_n = sel == E_ECALL ? E_ECALL + {2'b00, priv} : sel;
    mtval_n = sel == E_FETCH_MIS ? pc_e : sel[3:2] == 2'b01 ? i_alu_out_e : '0;
    state_n = idle ? (trap ? TRAP : i_mret_e ? MRET : IDLE) : state == TRAP ? REDIRECT : IDLE;
    o_kill_e = idle && (trap || i_mret_e);
    o_flush = !idle;
    o_busy = !idle;
    o_csr_we = state == TRAP;
    o_mepc = o_csr_we ? mepc_q : '0;
    o_mtval = o_csr_we ? mtval_q : '0;
    o_mcause = o_csr_we ? cause_q : 4'd0;
    o_mpp = o_csr_we ? priv_q : 2'b00;
    o_redirect_valid = state == REDIRECT || state == MRET;
    o_redirect_pc = state == REDIRECT ? {i_mtvec[W-1:2], 2'b00} : state == MRET ? i_mepc : '0;
    o_current_privilege = priv;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      code_d <= NO_E;
      pc_d <= '0;
      code_e <= NO_E;
      pc_e <= '0;
      cause_q <= 4'd0;
      mtval_q <= '0;
      mepc_q <= '0;
      priv_q <= 2'b00;
      priv <= RESET_PRIV;
      mpp <= 2'b00;
    end else begin
      state <= state_n;
      if (i_flush_d || o_flush) begin
        code_d <= NO_E;
        pc_d <= '0;
      end else if (!i_stall_d) begin
        code_d <= i_exception_code_f;
        pc_d <= i_pc_f;
      end
      if (i_flush_e || o_flush) begin
        code_e <= NO_E;
        pc_e <= '0;
      end else if (!i_stall_e) begin
        code_e <= code_d;
        pc_e <= pc_d;
      end
      if (trap) begin
        cause_q <= cause_n;
        mtval_q <= mtval_n;
        mepc_q <= i_pc_e;
        priv_q <= priv;
      end
      if (state == TRAP) begin
        priv <= MACHINE;
        mpp <= priv_q;
      end else if (state == MRET) begin
        priv <= mpp;
        mpp <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_exception_trap_controller.sv
// tb_exception_trap_controller: directed scenario tasks with hand-computed expectations
module tb_exception_trap_controller;
  localparam int W = 64;
  localparam logic [W-1:0] MTVEC = 64'h1003;
  localparam logic [W-1:0] MTVEC_AL = 64'h1000;
  logic i_clk = 1'b0;
  logic i_rst_n;
  logic [3:0] i_exception_code_f, i_exception_code_e;
  logic [W-1:0] i_pc_f, i_pc_e, i_alu_out_e, i_mtvec, i_mepc;
  logic i_stall_d, i_flush_d, i_stall_e, i_flush_e, i_mret_e;
  logic o_kill_e, o_flush, o_csr_we, o_redirect_valid, o_busy;
  logic [W-1:0] o_mepc, o_mtval, o_redirect_pc;
  logic [3:0] o_mcause;
  logic [1:0] o_mpp, o_current_privilege;
  int n_chk = 0;
  int n_fail = 0;
  exception_trap_controller dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exception_code_f(i_exception_code_f), .i_exception_code_e(i_exception_code_e),
    .i_pc_f(i_pc_f), .i_pc_e(i_pc_e), .i_alu_out_e(i_alu_out_e),
    .i_stall_d(i_stall_d), .i_flush_d(i_flush_d), .i_stall_e(i_stall_e), .i_flush_e(i_flush_e),
    .i_mret_e(i_mret_e), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_kill_e(o_kill_e), .o_flush(o_flush), .o_csr_we(o_csr_we),
    .o_mepc(o_mepc), .o_mtval(o_mtval), .o_mcause(o_mcause), .o_mpp(o_mpp),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_current_privilege(o_current_privilege), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic clr;
    i_exception_code_f = 4'hF;
    i_exception_code_e = 4'hF;
    i_pc_f = '0;
    i_pc_e = '0;
    i_alu_out_e = '0;
    i_stall_d = 1'b0;
    i_flush_d = 1'b0;
    i_stall_e = 1'b0;
    i_flush_e = 1'b0;
    i_mret_e = 1'b0;
    i_mtvec = MTVEC;
    i_mepc = 64'h200;
  endtask
  task automatic cyc;
    @(negedge i_clk);
  endtask
  task automatic test_reset;
    i_rst_n = 1'b0;
    clr;
    cyc;
    cyc;
    i_rst_n = 1'b1;
    #1;
    n_chk++;
    if ({o_kill_e, o_flush, o_csr_we, o_redirect_valid, o_busy, o_mcause, o_mpp, o_mepc, o_mtval, o_redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got kill=%b flush=%b we=%b rv=%b busy=%b want all 0", o_kill_e, o_flush, o_csr_we, o_redirect_valid, o_busy);
    end
    n_chk++;
    if (o_current_privilege !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_priv: got %0d want 3", o_current_privilege);
    end
  endtask
  task automatic test_mret_legal(input logic [1:0] exp_priv);
    cyc; i_mret_e = 1'b1; #1;
    n_chk++;
    if ({o_kill_e, o_csr_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL mret_kill: got kill=%b we=%b want kill=1 we=0", o_kill_e, o_csr_we);
    end
    cyc; clr; #1;
    n_chk++;
    if ({o_redirect_valid, o_redirect_pc, o_flush, o_csr_we, o_busy} !== {1'b1, 64'h200, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mret_redirect: got rv=%b pc=%h flush=%b we=%b want rv=1 pc=200 flush=1 we=0", o_redirect_valid, o_redirect_pc, o_flush, o_csr_we);
    end
    cyc; #1;
    n_chk++;
    if ({o_current_privilege, o_busy, o_redirect_valid} !== {exp_priv, 2'b00}) begin
      n_fail++;
      $display("FAIL mret_priv: got priv=%0d busy=%b rv=%b want priv=%0d busy=0 rv=0", o_current_privilege, o_busy, o_redirect_valid, exp_priv);
    end
  endtask
  task automatic test_trap(input string nm, input logic [3:0] code_e, input logic mret,
                           input logic [W-1:0] pc_e, input logic [W-1:0] alu, input logic stall_e,
                           input logic [3:0] exp_cause, input logic [W-1:0] exp_mtval, input logic [1:0] exp_mpp);
    cyc;
    i_exception_code_e = code_e;
    i_mret_e = mret;
    i_pc_e = pc_e;
    i_alu_out_e = alu;
    i_stall_e = stall_e;
    #1;
    n_chk++;
    if ({o_kill_e, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_kill: got kill=%b busy=%b want kill=1 busy=0", nm, o_kill_e, o_busy);
    end
    cyc; clr; #1;
    n_chk++;
    if ({o_csr_we, o_flush, o_busy, o_mcause, o_mepc, o_mtval, o_mpp, o_redirect_valid, o_current_privilege} !==
        {3'b111, exp_cause, pc_e, exp_mtval, exp_mpp, 1'b0, exp_mpp}) begin
      n_fail++;
      $display("FAIL %s_csr: got we=%b flush=%b cause=%0d mepc=%h mtval=%h mpp=%0d priv=%0d want we=1 flush=1 cause=%0d mepc=%h mtval=%h mpp=%0d",
               nm, o_csr_we, o_flush, o_mcause, o_mepc, o_mtval, o_mpp, o_current_privilege, exp_cause, pc_e, exp_mtval, exp_mpp);
    end
    cyc; #1;
    n_chk++;
    if ({o_redirect_valid, o_redirect_pc, o_flush, o_csr_we, o_current_privilege} !== {1'b1, MTVEC_AL, 1'b1, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL %s_redirect: got rv=%b pc=%h flush=%b we=%b priv=%0d want rv=1 pc=%h flush=1 we=0 priv=3",
               nm, o_redirect_valid, o_redirect_pc, o_flush, o_csr_we, o_current_privilege, MTVEC_AL);
    end
    cyc; #1;
    n_chk++;
    if ({o_busy, o_redirect_valid, o_kill_e} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b rv=%b kill=%b want 0", nm, o_busy, o_redirect_valid, o_kill_e);
    end
  endtask
  task automatic test_fetch_misaligned;
    cyc; i_exception_code_f = 4'd0; i_pc_f = 64'h102; #1;
    cyc; clr; #1;
    n_chk++;
    if (o_kill_e !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_early_kill: got %b want 0", o_kill_e);
    end
    test_trap("fetch_mis", 4'hF, 1'b0, 64'h102, 64'h0, 1'b0, 4'd0, 64'h102, 2'b11);
  endtask
  task automatic test_carried_priority;
    cyc; i_exception_code_f = 4'd2; i_pc_f = 64'h400; #1;
    cyc; clr; #1;
    test_trap("carried_prio", 4'd5, 1'b0, 64'h400, 64'h8000_0010, 1'b0, 4'd2, 64'h0, 2'b11);
  endtask
  task automatic test_flush_drop;
    cyc; i_exception_code_f = 4'd0; i_pc_f = 64'h900; i_flush_d = 1'b1; #1;
    cyc; clr; #1;
    for (int k = 0; k < 3; k++) begin
      cyc; #1;
      n_chk++;
      if ({o_kill_e, o_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_drop_%0d: got kill=%b busy=%b want 0", k, o_kill_e, o_busy);
      end
    end
  endtask
  task automatic test_simultaneous;
    cyc; i_exception_code_f = 4'd0; i_pc_f = 64'h600; #1;
    test_trap("simul", 4'd7, 1'b0, 64'h700, 64'h88, 1'b0, 4'd7, 64'h88, 2'b11);
    for (int k = 0; k < 4; k++) begin
      cyc; #1;
      n_chk++;
      if ({o_kill_e, o_busy, o_csr_we} !== 3'b000) begin
        n_fail++;
        $display("FAIL simul_f_leak_%0d: got kill=%b busy=%b we=%b want 0", k, o_kill_e, o_busy, o_csr_we);
      end
    end
  endtask
  task automatic test_reset_mid_trap;
    cyc; i_exception_code_e = 4'd4; i_alu_out_e = 64'h44; i_pc_e = 64'hA00; #1;
    cyc; clr; #1;
    n_chk++;
    if (o_csr_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_enter: got we=%b want 1", o_csr_we);
    end
    #1 i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_csr_we, o_flush, o_busy, o_redirect_valid, o_mcause, o_mtval, o_mepc, o_current_privilege} !== {8'h00, 128'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got we=%b flush=%b busy=%b rv=%b cause=%0d priv=%0d want 0s priv=3",
               o_csr_we, o_flush, o_busy, o_redirect_valid, o_mcause, o_current_privilege);
    end
    cyc; i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc; #1;
      n_chk++;
      if ({o_redirect_valid, o_csr_we, o_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_mid_after_%0d: got rv=%b we=%b busy=%b want 0", k, o_redirect_valid, o_csr_we, o_busy);
      end
    end
  endtask
  initial begin
    test_reset;
    test_mret_legal(2'b00);
    test_trap("ecall_u", 4'd8, 1'b0, 64'h300, 64'h55, 1'b0, 4'd8, 64'h0, 2'b00);
    test_mret_legal(2'b00);
    test_trap("mret_illegal", 4'hF, 1'b1, 64'h500, 64'h0, 1'b0, 4'd2, 64'h0, 2'b00);
    test_fetch_misaligned;
    test_trap("ecall_m", 4'd8, 1'b0, 64'h310, 64'h0, 1'b0, 4'd11, 64'h0, 2'b11);
    test_carried_priority;
    test_trap("load_fault", 4'd5, 1'b0, 64'h410, 64'h8000_0010, 1'b0, 4'd5, 64'h8000_0010, 2'b11);
    test_trap("store_stall", 4'd6, 1'b0, 64'h420, 64'h8000_0013, 1'b1, 4'd6, 64'h8000_0013, 2'b11);
    test_flush_drop;
    test_simultaneous;
    test_reset_mid_trap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
